// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional feature macro: IFETCH_ALIGN_CHECK_EN (misaligned-PC trap to NOP).
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned MAX_WAIT_DFLT = 15;
  localparam int unsigned WAIT_W        = $clog2(MAX_WAIT_DFLT + 1);

  // Counter width for a given watchdog limit; never below one bit.
  function automatic int unsigned wait_width(input int unsigned max_wait);
    return (max_wait > 0) ? $clog2(max_wait + 1) : 1;
  endfunction

endpackage

// File: rtl/ifetch_watchdog.sv
// Counts request cycles without an acknowledge and flags the abort cycle.
module ifetch_watchdog
  import ifetch_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic active,
  input  logic ack,
  output logic expire_c
);

  localparam int unsigned CNT_W = wait_width(MAX_WAIT);
  localparam int unsigned LAST  = (MAX_WAIT > 0) ? MAX_WAIT - 1 : 0;
  localparam bit          WD_ON = (MAX_WAIT > 0);

  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;

  // Abort when the last allowed cycle passes with no acknowledge.
  always_comb begin
    expire_c   = WD_ON && active && !ack && (wait_cnt_q == CNT_W'(LAST));
    wait_cnt_d = '0;
    if (active && !ack && !expire_c) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  // Wait counter register; cleared whenever the stage is not waiting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: one memory read per accepted PC, result handed to decode.
// Optional feature macro: IFETCH_ALIGN_CHECK_EN adds instr_misalign and NOP trap.
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned INSTR_W  = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               pc_valid,
  output logic               fetch_ready,
  input  logic               flush,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               fetch_err
`ifdef IFETCH_ALIGN_CHECK_EN
  ,
  output logic               instr_misalign
`endif
);

  state_e             state_q, state_d;
  logic               mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic               instr_valid_q, instr_valid_d;
  logic               fetch_err_q, fetch_err_d;
  logic               drop_q, drop_d;
  logic               accept_c;
  logic               misalign_c;
  logic               wd_expire_c;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic               misalign_q, misalign_d;
`endif

  ifetch_watchdog #(
    .MAX_WAIT (MAX_WAIT)
  ) u_watchdog (
    .clock    (clock),
    .reset    (reset),
    .active   (state_q == REQ),
    .ack      (mem_ack),
    .expire_c (wd_expire_c)
  );

  // New PC can be taken from IDLE, or from VALID in the cycle decode drains it.
  always_comb begin
    fetch_ready = !flush && ((state_q == IDLE) || ((state_q == VALID) && instr_ready));
    accept_c    = pc_valid && fetch_ready;
  end

`ifdef IFETCH_ALIGN_CHECK_EN
  // Low PC bits select the NOP trap path.
  always_comb begin
    misalign_c = (pc[1:0] != 2'b00);
  end
`else
  // Low PC bits have no meaning without the alignment check.
  logic unused_pc_lo;
  always_comb begin
    misalign_c   = 1'b0;
    unused_pc_lo = ^pc[1:0];
  end
`endif

  // Next-state and registered-output logic; an accepted PC overrides the drain path.
  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fetch_err_d   = 1'b0;
    drop_d        = drop_q;
`ifdef IFETCH_ALIGN_CHECK_EN
    misalign_d    = misalign_q;
`endif

    case (state_q)
      IDLE: begin
      end
      REQ: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          if (drop_q || flush) begin
            state_d = IDLE;
          end else begin
            instr_d       = mem_rdata;
            instr_valid_d = 1'b1;
            state_d       = VALID;
          end
        end else if (wd_expire_c) begin
          mem_req_d   = 1'b0;
          fetch_err_d = 1'b1;
          drop_d      = 1'b0;
          state_d     = IDLE;
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      VALID: begin
        if (flush || instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = IDLE;
`ifdef IFETCH_ALIGN_CHECK_EN
          misalign_d    = 1'b0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept_c) begin
      instr_pc_d = pc;
      drop_d     = 1'b0;
      if (misalign_c) begin
        instr_d       = INSTR_W'(NOP_INSTR);
        instr_valid_d = 1'b1;
        state_d       = VALID;
`ifdef IFETCH_ALIGN_CHECK_EN
        misalign_d    = 1'b1;
`endif
      end else begin
        mem_req_d  = 1'b1;
        mem_addr_d = {pc[ADDR_W-1:2], 2'b00};
        state_d    = REQ;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      drop_q        <= 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fetch_err_q   <= fetch_err_d;
      drop_q        <= drop_d;
`ifdef IFETCH_ALIGN_CHECK_EN
      misalign_q    <= misalign_d;
`endif
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign fetch_err   = fetch_err_q;
`ifdef IFETCH_ALIGN_CHECK_EN
  assign instr_misalign = misalign_q;
`endif

endmodule
